// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit shared definitions: op and FSM encodings,
// word width and an op-decoding helper.
package mul_div_unit_pkg;

    localparam int MDU_WORD_W = 32;

    typedef enum logic [1:0] {
        MDU_OP_MULT  = 2'b00,
        MDU_OP_MULTU = 2'b01,
        MDU_OP_DIV   = 2'b10,
        MDU_OP_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    // Signed variants have op[0] clear
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_mul(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/mul_div_unit_sign_fix.sv
// Sign handling for the MDU: operand magnitudes at entry
// and sign correction of the raw unsigned result in FIX.
module mul_div_unit_sign_fix
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WORD_W
) (
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   abs_a,
    output logic [WIDTH-1:0]   abs_b,
    output logic               a_neg,
    output logic               b_neg,
    input  logic               is_mul,
    input  logic               qsign,
    input  logic               rsign,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   hi_res,
    output logic [WIDTH-1:0]   lo_res
);

    logic [2*WIDTH-1:0] prod;

    // Magnitudes are modulo 2^WIDTH, so the most negative value maps to itself
    always_comb begin
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        abs_a = a_neg ? -a : a;
        abs_b = b_neg ? -b : b;
    end

    // Product negates as one double word; quotient and remainder separately
    always_comb begin
        prod = qsign ? -raw : raw;
        if (is_mul) begin
            hi_res = prod[2*WIDTH-1:WIDTH];
            lo_res = prod[WIDTH-1:0];
        end else begin
            hi_res = rsign ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
            lo_res = qsign ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit owning HI/LO.
// One step per cycle, sign fix in FIX, done pulse in DONE.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MDU_WORD_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opnd_a,
    input  logic [WIDTH-1:0] opnd_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   dvs_q;
    logic [2*WIDTH:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_mul_q, qsign_q, rsign_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, last;
    logic [WIDTH-1:0]   abs_a, abs_b, hi_res, lo_res;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     mul_sum, div_top, div_rem;
    logic               div_ge;
    logic [2*WIDTH:0]   step;

    assign busy   = (state_q == MDU_CALC) || (state_q == MDU_FIX);
    assign done   = (state_q == MDU_DONE);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign accept = start & ~flush & ~busy;
    assign last   = (cnt_q == CNT_W'(WIDTH - 1));

    mul_div_unit_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sgn    (op_is_signed(op)),
        .a      (opnd_a),
        .b      (opnd_b),
        .abs_a  (abs_a),
        .abs_b  (abs_b),
        .a_neg  (a_neg),
        .b_neg  (b_neg),
        .is_mul (is_mul_q),
        .qsign  (qsign_q),
        .rsign  (rsign_q),
        .raw    (acc_q[2*WIDTH-1:0]),
        .hi_res (hi_res),
        .lo_res (lo_res)
    );

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    always_comb begin
        mul_sum = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, dvs_q} : '0);
        div_top = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge  = div_top >= {1'b0, dvs_q};
        div_rem = div_ge ? div_top - {1'b0, dvs_q} : div_top;
        if (is_mul_q)
            step = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        else
            step = {div_rem, acc_q[WIDTH-2:0], div_ge};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= MDU_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush beats start and aborts CALC/FIX
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MDU_IDLE, MDU_DONE:
                state_d = accept ? MDU_CALC : MDU_IDLE;
            MDU_CALC:
                if (flush)     state_d = MDU_IDLE;
                else if (last) state_d = MDU_FIX;
            MDU_FIX:
                state_d = flush ? MDU_IDLE : MDU_DONE;
            default:
                state_d = MDU_IDLE;
        endcase
    end

    // Operand latch at accept, then iterate; zero divisor keeps quotient positive
    always_ff @(posedge clk) begin
        if (rst) begin
            dvs_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
        end else if (accept) begin
            is_mul_q <= op_is_mul(op);
            cnt_q    <= '0;
            if (op_is_mul(op)) begin
                dvs_q   <= abs_a;
                acc_q   <= {{(WIDTH+1){1'b0}}, abs_b};
                qsign_q <= a_neg ^ b_neg;
                rsign_q <= 1'b0;
            end else begin
                dvs_q   <= abs_b;
                acc_q   <= {{(WIDTH+1){1'b0}}, abs_a};
                qsign_q <= (a_neg ^ b_neg) & (|opnd_b);
                rsign_q <= a_neg;
            end
        end else if (state_q == MDU_CALC) begin
            acc_q <= step;
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // HI/LO: FIX result, else MTHI/MTLO while not busy
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state_q == MDU_FIX && !flush) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
        end else if (!busy) begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
        end
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS core's EX stage.
- Handles MULT, MULTU, DIV and DIVU, which the combinational ALU does not.
- Owns the architectural HI/LO registers, which MTHI/MTLO also write.
- Start/busy/done handshake with the pipeline controller, plus a flush input for exception squash.

Parameters:
- WIDTH, 32, operand width; HI/LO each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request; sampled only when busy=0
- op  in  2  MDU_OP_MULT=00, MDU_OP_MULTU=01, MDU_OP_DIV=10, MDU_OP_DIVU=11
- opnd_a  in  WIDTH  multiplicand / dividend
- opnd_b  in  WIDTH  multiplier / divisor
- flush  in  1  abort the in-flight operation
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in flight; pipeline stalls MFHI/MFLO and new mul/div
- done  out  1  one-cycle pulse: HI/LO updated this cycle
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and datapath regs cleared. Reset overrides every other input, including mid-operation.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 latches op, |a|, |b|, quotient/product sign and remainder sign (signed ops only), counter=0.
  - Goes to CALC.
- CALC: one radix-2 step per cycle for exactly WIDTH cycles, then FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
- FIX:
  - Applies sign correction: quotient/product negated if the sign flag is set; remainder takes the sign of the dividend.
  - Writes HI/LO at the end of the cycle. Multiply: HI=product[63:32], LO=product[31:0]. Divide: LO=quotient, HI=remainder.
  - Goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start is also accepted in DONE, i.e. back-to-back.
- Timing: start in cycle 0 gives busy=1 in cycles 1..WIDTH+1 and done=1 in cycle WIDTH+2 (34 for WIDTH=32). hi/lo carry the new values from cycle WIDTH+2 onward.
- Signed absolute value is computed modulo 2^WIDTH. Therefore DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no overflow flag is produced.
- Divide by zero (b=0): fixed latency as normal; LO=0xFFFFFFFF, HI=opnd_a unmodified, for both DIV and DIVU.
- start while busy=1: ignored, no queueing.
- flush=1 in CALC or FIX: next state IDLE, busy=0 next cycle, no done pulse, HI/LO unchanged.
- flush and start in the same cycle in IDLE/DONE: flush wins, start is dropped.
- MTHI/MTLO:
  - hi_we/lo_we write in 1 cycle and are honoured only when busy=0.
  - If a write coincides with FIX completing, the FIX result wins.
  - A write in the same cycle as an accepted start is performed, then overwritten at FIX.
- hi/lo are driven directly from the registers, never from intermediate datapath values.

Decomposition:
- Shared package/header mdu.vh holds:
  - MDU_OP_* encodings
  - MDU state encodings
  - MDU_WORD_W = 32
- Optional sub-module mdu_sign_fix: combinational abs/negate and result sign correction, used at entry and in FIX.
- The iterative datapath stays in mul_div_unit.

Test Plan:
1. MULT a=0xFFFFFFFE (-2), b=3 -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high in cycles 1..33 only.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then back-to-back MULTU 0x10000 * 0x10000 started in the done cycle -> hi=0x00000001, lo=0, done 34 cycles later.
3. Division signs:
   - DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 7 / 2 -> lo=3, hi=1.
   - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIV a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 at cycle 34.
5. Abort and collision:
   - MULTU started, flush at cycle 10 -> busy=0 in cycle 11, done never pulses, hi/lo keep prior values.
   - start pulsed at cycle 5 while busy -> ignored.
6. Register writes and reset:
   - hi_we with wdata=0xA5A5A5A5 while idle -> hi=0xA5A5A5A5 next cycle.
   - lo_we while busy -> ignored.
   - rst asserted at cycle 20 of a DIV -> hi=lo=0, busy=0, done=0 next cycle, no done pulse afterwards.
